// File: rtl/camera_pixel_capture_pkg.sv
// -----------------------------------------------------------------------------
// camera_pixel_capture_pkg
// Shared definitions for the camera-to-frame-buffer writer and the VGA read
// side: default frame geometry, RGB332 colour constants and the capture FSM
// state encoding.
// -----------------------------------------------------------------------------
package camera_pixel_capture_pkg;

  // Stored frame geometry (QCIF), shared with the VGA scan-out side.
  localparam int DEF_SCREEN_WIDTH  = 176;
  localparam int DEF_SCREEN_HEIGHT = 144;

  // RGB332 primaries.
  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;

  // Capture FSM states. BYTE_HI / BYTE_LO name the byte expected next.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VBLANK    = 3'd1,
    ST_LINE_WAIT = 3'd2,
    ST_BYTE_HI   = 3'd3,
    ST_BYTE_LO   = 3'd4
  } cap_state_t;

endpackage

// File: rtl/camera_pixel_capture_rgb565_to_rgb332.sv
// -----------------------------------------------------------------------------
// rgb565_to_rgb332
// Pure combinational packer: takes the two bytes of an RGB565 pixel as sent by
// the OV7670 (high byte first) and keeps the top bits of each channel.
//   hi  : RRRRRGGG  (first byte)
//   lo  : GGGBBBBB  (second byte)
//   pix : RRRGGGBB  = {R[4:2], G[5:3], B[4:3]}
// -----------------------------------------------------------------------------
module rgb565_to_rgb332 (
  input  logic [7:0] hi,
  input  logic [7:0] lo,
  output logic [7:0] pix
);

  assign pix = {hi[7:5], hi[2:0], lo[4:3]};

  // Low-order colour bits are intentionally discarded.
  logic unused_bits;
  assign unused_bits = ^{hi[4:3], lo[7:5], lo[2:0]};

endmodule

// File: rtl/camera_pixel_capture.sv
// -----------------------------------------------------------------------------
// camera_pixel_capture
// Writer side of the frame-buffer path. Captures the OV7670 RGB565 byte stream,
// packs each pixel to RGB332 and produces a linear write address
// (line base + X) and one-cycle write strobe for the dual-port M9K buffer.
// Everything runs in the camera pixel-clock domain.
//
// Ports:
//   CLK         camera pixel clock (inputs sampled on rising edge)
//   RESET       asynchronous, active-high reset
//   CAM_DATA    camera byte bus
//   CAM_HREF    high while line bytes are valid
//   CAM_VSYNC   high during vertical blanking
//   CAPTURE_EN  arms capture; sampled only at frame start
//   W_ADDR      frame-buffer write address
//   W_DATA      RGB332 pixel
//   W_EN        one-cycle write strobe per stored pixel
//   FRAME_DONE  one-cycle pulse when a captured frame ends
//   LINE_ERR    one-cycle pulse when a line ends with an odd byte count
//
// Build option: define CAMERA_TEST_PATTERN_EN to replace W_DATA with
// red/green/blue vertical bars (CAM_DATA ignored, timing unchanged).
// -----------------------------------------------------------------------------
module camera_pixel_capture
  import camera_pixel_capture_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int ADDR_W        = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        CAM_DATA,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic              CAPTURE_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              LINE_ERR
);

  localparam logic [ADDR_W-1:0] WIDTH_L  = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] HEIGHT_L = ADDR_W'(SCREEN_HEIGHT);

  // ---------------------------------------------------------------------------
  // Stage p0: register camera inputs; vsync_p1 is kept for edge detection.
  // ---------------------------------------------------------------------------
  logic [7:0] data_p0;
  logic       href_p0;
  logic       vsync_p0;
  logic       vsync_p1;
  logic       capen_p0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      href_p0  <= 1'b0;
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
      capen_p0 <= 1'b0;
    end else begin
      href_p0  <= CAM_HREF;
      vsync_p0 <= CAM_VSYNC;
      vsync_p1 <= vsync_p0;
      capen_p0 <= CAPTURE_EN;
    end
  end

  always_ff @(posedge CLK) begin
    data_p0 <= CAM_DATA;
  end

  logic vsync_fall;
  assign vsync_fall = vsync_p1 & ~vsync_p0;

  // ---------------------------------------------------------------------------
  // Capture FSM (state register / next state / outputs).
  // ---------------------------------------------------------------------------
  cap_state_t state;
  cap_state_t state_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // The first byte of a line is consumed on the very cycle HREF is seen, so the
  // high-byte phase for that pixel happens in LINE_WAIT and the FSM moves on to
  // expecting the low byte. VSYNC takes priority over every line event.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (vsync_p0) state_next = ST_VBLANK;
      ST_VBLANK:    if (vsync_fall && capen_p0) state_next = ST_LINE_WAIT;
      ST_LINE_WAIT: begin
        if (vsync_p0)     state_next = ST_VBLANK;
        else if (href_p0) state_next = ST_BYTE_LO;
      end
      ST_BYTE_HI: begin
        if (vsync_p0)     state_next = ST_VBLANK;
        else if (href_p0) state_next = ST_BYTE_LO;
        else              state_next = ST_LINE_WAIT;
      end
      ST_BYTE_LO: begin
        if (vsync_p0)     state_next = ST_VBLANK;
        else if (href_p0) state_next = ST_BYTE_HI;
        else              state_next = ST_LINE_WAIT;
      end
      default:            state_next = ST_IDLE;
    endcase
  end

  logic latch_hi;
  logic launch;
  logic line_adv;
  logic line_err_set;
  logic frame_done_set;
  logic frame_start;

  always_comb begin
    latch_hi       = 1'b0;
    launch         = 1'b0;
    line_adv       = 1'b0;
    line_err_set   = 1'b0;
    frame_done_set = 1'b0;
    frame_start    = 1'b0;
    unique case (state)
      ST_VBLANK:    frame_start = vsync_fall & capen_p0;
      ST_LINE_WAIT: begin
        if (vsync_p0)     frame_done_set = 1'b1;
        else if (href_p0) latch_hi       = 1'b1;
      end
      ST_BYTE_HI: begin
        if (vsync_p0)     frame_done_set = 1'b1;
        else if (href_p0) latch_hi       = 1'b1;
        else              line_adv       = 1'b1;
      end
      ST_BYTE_LO: begin
        // A high byte is pending here; losing HREF now means an odd line.
        if (vsync_p0) begin
          frame_done_set = 1'b1;
          line_err_set   = ~href_p0;
        end else if (href_p0) begin
          launch = 1'b1;
        end else begin
          line_adv     = 1'b1;
          line_err_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p1: pixel assembly, address counters and registered outputs.
  // ---------------------------------------------------------------------------
  logic [7:0]        hi_byte;
  logic [7:0]        conv_pix;
  logic [7:0]        pix_next;
  logic [ADDR_W-1:0] x_cnt;
  logic [ADDR_W-1:0] y_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              in_range;
  logic              write_px;

  always_ff @(posedge CLK) begin
    if (latch_hi) hi_byte <= data_p0;
  end

  rgb565_to_rgb332 u_pack (
    .hi  (hi_byte),
    .lo  (data_p0),
    .pix (conv_pix)
  );

`ifdef CAMERA_TEST_PATTERN_EN
  localparam logic [ADDR_W-1:0] THIRD_L     = ADDR_W'(SCREEN_WIDTH / 3);
  localparam logic [ADDR_W-1:0] TWO_THIRD_L = ADDR_W'((2 * SCREEN_WIDTH) / 3);

  always_comb begin
    pix_next = BLUE;
    if (x_cnt < THIRD_L)          pix_next = RED;
    else if (x_cnt < TWO_THIRD_L) pix_next = GREEN;
  end

  logic unused_conv;
  assign unused_conv = ^conv_pix;
`else
  assign pix_next = conv_pix;
`endif

  assign in_range = (x_cnt < WIDTH_L) && (y_cnt < HEIGHT_L);
  assign write_px = launch & in_range;

  // Counters saturate at the frame edge so clipped pixels never alias back
  // into low addresses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      line_base <= '0;
    end else if (frame_start) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      line_base <= '0;
    end else if (line_adv) begin
      x_cnt <= '0;
      if (y_cnt < HEIGHT_L) begin
        y_cnt     <= y_cnt + 1'b1;
        line_base <= line_base + WIDTH_L;
      end
    end else if (launch && (x_cnt < WIDTH_L)) begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      W_ADDR     <= '0;
      W_DATA     <= '0;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;
    end else begin
      W_EN       <= write_px;
      FRAME_DONE <= frame_done_set;
      LINE_ERR   <= line_err_set;
      if (write_px) begin
        W_ADDR <= line_base + x_cnt;
        W_DATA <= pix_next;
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// -----------------------------------------------------------------------------
// tb_camera_pixel_capture
// Directed bench for camera_pixel_capture: a table of RGB565 byte pairs with
// hand-computed RGB332 results, plus hand-written frame sequences for reset,
// clipping, odd lines, skipped frames and VSYNC/HREF collisions.
// -----------------------------------------------------------------------------
module tb_camera_pixel_capture;

  logic        clk;
  logic        rst;
  logic [7:0]  cam_data;
  logic        cam_href;
  logic        cam_vsync;
  logic        capture_en;
  logic [14:0] w_addr;
  logic [7:0]  w_data;
  logic        w_en;
  logic        frame_done;
  logic        line_err;

  camera_pixel_capture dut (
    .CLK        (clk),
    .RESET      (rst),
    .CAM_DATA   (cam_data),
    .CAM_HREF   (cam_href),
    .CAM_VSYNC  (cam_vsync),
    .CAPTURE_EN (capture_en),
    .W_ADDR     (w_addr),
    .W_DATA     (w_data),
    .W_EN       (w_en),
    .FRAME_DONE (frame_done),
    .LINE_ERR   (line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write log and pulse counters, sampled on the falling edge.
  logic [14:0] addr_q[$];
  logic [7:0]  data_q[$];
  int          fd_cnt = 0;
  int          le_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) begin
        addr_q.push_back(w_addr);
        data_q.push_back(w_data);
      end
      if (frame_done) fd_cnt++;
      if (line_err)   le_cnt++;
    end
  end

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Expected stored pixel at column x given the normally converted value.
  function automatic logic [7:0] exp_pix(input int x, input logic [7:0] normal);
`ifdef CAMERA_TEST_PATTERN_EN
    if (x < 58) return 8'hE0;
    if (x < 117) return 8'h1C;
    return 8'h03;
`else
    if (x < 0) return 8'h00;
    return normal;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    idle(4);
    cam_vsync = 1'b0;
    idle(4);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b_hi, input logic [7:0] b_lo);
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      cam_data = (i % 2 == 0) ? b_hi : b_lo;
      tick();
    end
    cam_href = 1'b0;
    idle(3);
  endtask

  int n0;
  int fd0;
  int le0;
  int cnt;
  int order_err;
  int data_err;

  initial begin
    tbl[0] = '{hi: 8'hE3, lo: 8'h18, exp: 8'hEF};
    tbl[1] = '{hi: 8'h00, lo: 8'h00, exp: 8'h00};
    tbl[2] = '{hi: 8'hFF, lo: 8'hFF, exp: 8'hFF};
    tbl[3] = '{hi: 8'hF8, lo: 8'h00, exp: 8'hE0};
    tbl[4] = '{hi: 8'h07, lo: 8'hE0, exp: 8'h1C};
    tbl[5] = '{hi: 8'h00, lo: 8'h1F, exp: 8'h03};
    tbl[6] = '{hi: 8'hA5, lo: 8'h5A, exp: 8'hB7};
    tbl[7] = '{hi: 8'h12, lo: 8'h34, exp: 8'h0A};

    rst        = 1'b1;
    cam_data   = 8'h00;
    cam_href   = 1'b0;
    cam_vsync  = 1'b0;
    capture_en = 1'b1;
    idle(3);

    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_en", w_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_err", line_err, 0);

    rst = 1'b0;
    idle(2);

    // Start a frame, then reset in the middle of an active line.
    vsync_pulse();
    cam_href = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cam_data = 8'h55;
      tick();
    end
    #2 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n0  = addr_q.size();
    fd0 = fd_cnt;
    for (int i = 0; i < 20; i++) begin
      cam_data = 8'hAA;
      tick();
    end
    cam_href = 1'b0;
    idle(3);
    repeat (4) send_line(40, 8'hE3, 8'h18);
    check("post_reset_writes", addr_q.size() - n0, 0);
    check("post_reset_frame_done", fd_cnt - fd0, 0);

    // First VSYNC after reset only arms; no frame was being captured.
    vsync_pulse();
    check("arm_vsync_frame_done", fd_cnt - fd0, 0);
    n0 = addr_q.size();
    send_line(6, 8'hE3, 8'h18);
    check("restart_count", addr_q.size() - n0, 3);
    check("restart_first_addr", addr_q[n0], 0);
    check("restart_third_addr", addr_q[n0 + 2], 2);

    // Table-driven conversion frame.
    fd0 = fd_cnt;
    vsync_pulse();
    check("restart_frame_done", fd_cnt - fd0, 1);
    n0 = addr_q.size();
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cam_data = tbl[i].hi;
      tick();
      cam_data = tbl[i].lo;
      tick();
    end
    cam_href = 1'b0;
    idle(3);

    // Second line: single pixel with cycle-exact strobe timing.
    cam_href = 1'b1;
    cam_data = 8'hE3;
    tick();
    cam_data = 8'h18;
    tick();
    cam_href = 1'b0;
    check("lat_early_w_en", w_en, 0);
    tick();
    check("lat_w_en", w_en, 1);
    check("lat_w_addr", w_addr, 176);
    check("lat_w_data", w_data, exp_pix(0, 8'hEF));
    tick();
    check("lat_w_en_off", w_en, 0);
    idle(3);

    check("tbl_count", addr_q.size() - n0, 9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tbl_addr_%0d", i), addr_q[n0 + i], i);
      check($sformatf("tbl_data_%0d", i), data_q[n0 + i], exp_pix(i, tbl[i].exp));
    end

    // Odd-length line: 351 bytes leaves a dangling high byte.
    fd0 = fd_cnt;
    vsync_pulse();
    check("tbl_frame_done", fd_cnt - fd0, 1);
    n0  = addr_q.size();
    le0 = le_cnt;
    send_line(351, 8'hE3, 8'h18);
    check("odd_line_err_once", le_cnt - le0, 1);
    send_line(4, 8'hE3, 8'h18);
    check("odd_count", addr_q.size() - n0, 177);
    check("odd_last_addr", addr_q[n0 + 174], 174);
    check("odd_next_line_addr", addr_q[n0 + 175], 176);
    check("odd_line_err_total", le_cnt - le0, 1);

    // Capture disabled at VSYNC fall, raised mid-frame: frame skipped.
    capture_en = 1'b0;
    fd0 = fd_cnt;
    vsync_pulse();
    check("odd_frame_done", fd_cnt - fd0, 1);
    n0 = addr_q.size();
    send_line(20, 8'hE3, 8'h18);
    capture_en = 1'b1;
    send_line(20, 8'hE3, 8'h18);
    send_line(20, 8'hE3, 8'h18);
    check("skip_writes", addr_q.size() - n0, 0);
    fd0 = fd_cnt;
    vsync_pulse();
    check("skip_frame_done", fd_cnt - fd0, 0);
    n0 = addr_q.size();
    send_line(8, 8'hE3, 8'h18);
    check("after_skip_count", addr_q.size() - n0, 4);
    check("after_skip_first_addr", addr_q[n0], 0);

    // Oversized frame: 146 lines of 180 pixels, clipped to 176x144.
    fd0 = fd_cnt;
    vsync_pulse();
    check("after_skip_frame_done", fd_cnt - fd0, 1);
    n0  = addr_q.size();
    le0 = le_cnt;
    repeat (146) send_line(360, 8'hE3, 8'h18);
    fd0 = fd_cnt;
    cam_vsync = 1'b1;
    idle(4);
    check("full_frame_done", fd_cnt - fd0, 1);
    cam_vsync = 1'b0;
    idle(4);
    cnt = addr_q.size() - n0;
    check("full_count", cnt, 25344);
    order_err = 0;
    data_err  = 0;
    for (int i = 0; i < cnt; i++) begin
      if (addr_q[n0 + i] !== 15'(i)) order_err++;
      if (data_q[n0 + i] !== exp_pix(i % 176, 8'hEF)) data_err++;
    end
    check("full_order_errs", order_err, 0);
    check("full_data_errs", data_err, 0);
    check("full_first_addr", addr_q[n0], 0);
    check("full_last_addr", addr_q[n0 + cnt - 1], 25343);
    check("full_line_err", le_cnt - le0, 0);

    // HREF falls and VSYNC rises together with a high byte pending.
    n0  = addr_q.size();
    le0 = le_cnt;
    fd0 = fd_cnt;
    cam_href = 1'b1;
    cam_data = 8'hE3;
    tick();
    cam_data = 8'h18;
    tick();
    cam_data = 8'hE3;
    tick();
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    idle(4);
    cam_vsync = 1'b0;
    idle(4);
    check("collide_writes", addr_q.size() - n0, 1);
    check("collide_line_err", le_cnt - le0, 1);
    check("collide_frame_done", fd_cnt - fd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
